// File: rtl/root_to_bcd.sv
// Fixed-point square-root result (8.8) to four BCD digits II.FF via shift-add scaling and double dabble.
// Define ROOT_TO_BCD_ROUND_EN to round the hundredths to nearest instead of truncating.
module root_to_bcd (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] root,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] bcd,
    output logic        sat
);
    localparam int VW = 11;
    localparam int SW = 16 + VW;
    localparam logic [3:0] LAST_IT = 4'd10;

    typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   root_q, root_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          sat_q, sat_d;

    logic [14:0]   frac_x100;
    logic [14:0]   frac_sum;
    logic [6:0]    hund;
    logic [10:0]   int_x100;
    logic [VW-1:0] value;
    logic [SW-1:0] dabbled;

    // x*100 = x*64 + x*32 + x*4
    always_comb begin
        frac_x100 = ({7'd0, root_q[7:0]} << 6) + ({7'd0, root_q[7:0]} << 5)
                  + ({7'd0, root_q[7:0]} << 2);
`ifdef ROOT_TO_BCD_ROUND_EN
        frac_sum  = frac_x100 + 15'd128;
`else
        frac_sum  = frac_x100;
`endif
        hund      = 7'(frac_sum >> 8);
        int_x100  = ({7'd0, root_q[11:8]} << 6) + ({7'd0, root_q[11:8]} << 5)
                  + ({7'd0, root_q[11:8]} << 2);
        value     = int_x100 + {4'd0, hund};
    end

    // One double-dabble step: correct each BCD nibble, then shift the whole register.
    always_comb begin
        dabbled = shreg_q;
        for (int i = 0; i < 4; i++) begin
            if (shreg_q[VW+4*i +: 4] >= 4'd5)
                dabbled[VW+4*i +: 4] = shreg_q[VW+4*i +: 4] + 4'd3;
        end
        dabbled = dabbled << 1;
    end

    always_comb begin
        state_d = state_q;
        root_d  = root_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    root_d  = root;
                    state_d = CALC;
                end
            end
            CALC: begin
                shreg_d = {16'd0, value};
                cnt_d   = 4'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                shreg_d = dabbled;
                cnt_d   = cnt_q + 4'd1;
                // Last iteration lands the digits straight into the output register.
                if (cnt_q == LAST_IT) begin
                    state_d = DONE;
                    sat_d   = |root_q[15:12];
                    bcd_d   = (|root_q[15:12]) ? 16'h9999 : dabbled[SW-1:VW];
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            root_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            root_q  <= root_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;
    assign sat       = sat_q;

endmodule

// File: doc/root_to_bcd.md
ROOT_TO_BCD -- requirements
Module: root_to_bcd

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1, root operand valid.
REQ-004 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-005 SHALL have port root, input, 16, unsigned fixed-point value: bits [15:8] are the integer part and bits [7:0] are the fraction, as produced by the square-root stage.
REQ-006 SHALL have port out_valid, output, 1, result valid.
REQ-007 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-008 SHALL have port bcd, output, 16, four BCD digits II.FF: [15:12] tens, [11:8] units, [7:4] tenths, [3:0] hundredths.
REQ-009 SHALL have port sat, output, 1, the result was saturated.

Function
REQ-010 SHALL use FSM states IDLE, CALC, SHIFT and DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-011 SHALL accept the operand on an edge with in_valid&&in_ready, register root, and go to CALC.
REQ-012 SHALL, in CALC, compute V = int*100 + H in 11 bits, with H = (frac*100)>>8 using shift-add only (no multiplier), then go to SHIFT with the bit counter cleared.
REQ-013 SHALL, in SHIFT, run exactly 11 double-dabble iterations, one per cycle (add 3 to every BCD nibble >=5, then shift left), then go to DONE.
REQ-014 SHALL, on entering DONE, load bcd and sat together; out_valid rises 12 edges after the accepting edge.
REQ-015 SHALL hold out_valid, bcd and sat stable in DONE until out_ready=1, then go to IDLE, so the next operand can be accepted no earlier than the following edge.
REQ-016 SHALL, if root[15:12] != 0 (integer part >15), force bcd=16'h9999 and sat=1 with the same 12-cycle latency; otherwise sat=0.
REQ-017 SHALL keep bcd holding the last result outside DONE, and SHALL ignore in_valid while not in IDLE.
REQ-018 SHALL produce V in the range 0..1600; the rounding carry from H=100 propagates into the integer digits.

Reset
REQ-019 SHALL, while reset=1, go to IDLE immediately regardless of clk, with in_ready=1, out_valid=0, bcd=16'h0000 and sat=0.
REQ-020 SHALL, on reset during CALC, SHIFT or DONE, discard the operation in progress and emit no result for it.

Configuration
REQ-021 SHALL, with macro ROOT_TO_BCD_ROUND_EN defined, compute H = (frac*100 + 128)>>8, i.e. round to nearest, where H=100 carries into the integer part.
REQ-022 SHALL, with ROOT_TO_BCD_ROUND_EN undefined, truncate H = (frac*100)>>8 (maximum 99); latency is identical in both builds.

Verification
REQ-023 SHALL cover: root=16'h0180 (1.5) -> bcd=16'h0150, sat=0, with out_valid exactly 12 edges after the accept.
REQ-024 SHALL cover: root=16'h0FF9 (15.97) -> bcd=16'h1597; root=16'h0000 -> bcd=16'h0000.
REQ-025 SHALL cover: root=16'h03FF -> bcd=16'h0400 with ROOT_TO_BCD_ROUND_EN, and bcd=16'h0399 without it.
REQ-026 SHALL cover: root=16'h1000 -> bcd=16'h9999, sat=1.
REQ-027 SHALL cover: out_ready=0 for 20 cycles in DONE -> out_valid, bcd and in_ready=0 all held; a new in_valid in that window is ignored.
REQ-028 SHALL cover: reset pulse in the 5th SHIFT cycle -> out_valid=0, in_ready=1 and bcd=0 at once, and the next operand converts correctly.
